// File: rtl/sw_debounce_rx_pkg.sv
// Shared constants and types for the slide-switch debounce receiver.
// Holds debounce lengths (board and bench) and counter width derivation.
package sw_debounce_rx_pkg;

    localparam int EVT_W = 8;

    // Smallest width w with 2**w > cycles, so cycles-1 always fits.
    function automatic int cnt_w_for(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int DEBOUNCE_CYCLES_SIM  = 4;
    localparam int DEBOUNCE_CYCLES_10MS = 1000000;
    localparam int CNT_W_SIM            = cnt_w_for(DEBOUNCE_CYCLES_SIM);
    localparam int CNT_W_10MS           = cnt_w_for(DEBOUNCE_CYCLES_10MS);

    typedef logic [EVT_W-1:0] evt_cnt_t;

endpackage

// File: rtl/sw_debounce_rx_if.sv
// Switch bundle: raw pins in, debounced levels, edge pulses, event count out.
// master drives SW (board side); slave is the debouncer producing the rest.
interface sw_debounce_rx_if
    import sw_debounce_rx_pkg::*;
#(
    parameter int N = 16
);
    logic [N-1:0] SW;
    logic [N-1:0] SW_CLEAN;
    logic [N-1:0] SW_RISE;
    logic [N-1:0] SW_FALL;
    logic         SW_EVENT;
    evt_cnt_t     EVT_CNT;

    modport master (
        output SW,
        input  SW_CLEAN,
        input  SW_RISE,
        input  SW_FALL,
        input  SW_EVENT,
        input  EVT_CNT
    );

    modport slave (
        input  SW,
        output SW_CLEAN,
        output SW_RISE,
        output SW_FALL,
        output SW_EVENT,
        output EVT_CNT
    );
endinterface

// File: rtl/sw_debounce_rx_debounce_ch.sv
// One switch channel: 2-flop synchronizer, stability counter, clean level.
// Ports: clk, rst (async high), sw raw pin; clean level, rise/fall pulses.
module debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic clean,
    output logic rise,
    output logic fall
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= sw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            // Any agreement with the accepted level restarts the count.
            if (s2 == clean) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                clean <= s2;
                cnt   <= '0;
                rise  <= s2;
                fall  <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_debounce_rx.sv
// Debounce receiver for the board slide switches, one instance for all.
// Ports: CLK, RST (async high), bus (slave): SW in; SW_CLEAN, SW_RISE,
// SW_FALL, SW_EVENT (OR of pulses), EVT_CNT (event cycles, mod 256) out.
module sw_debounce_rx
    import sw_debounce_rx_pkg::*;
#(
    parameter int N               = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS,
    parameter int CNT_W           = CNT_W_10MS
) (
    input  logic               CLK,
    input  logic               RST,
    sw_debounce_rx_if.slave    bus
);
    logic [N-1:0] clean;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         evt;
    evt_cnt_t     cnt;

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk  (CLK),
            .rst  (RST),
            .sw   (bus.SW[i]),
            .clean(clean[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    // Built only from registered pulses, so free of glitches.
    assign evt = |(rise | fall);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (evt) begin
            cnt <= cnt + evt_cnt_t'(1);
        end
    end

    assign bus.SW_CLEAN = clean;
    assign bus.SW_RISE  = rise;
    assign bus.SW_FALL  = fall;
    assign bus.SW_EVENT = evt;
    assign bus.EVT_CNT  = cnt;

endmodule

// File: tb/tb_sw_debounce_rx.sv
// Bench for sw_debounce_rx: window-based reference model plus directed cases.
// Runs with DEBOUNCE_CYCLES=4, CNT_W=3.
module tb_sw_debounce_rx;
    import sw_debounce_rx_pkg::*;

    localparam int D = DEBOUNCE_CYCLES_SIM;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sw_debounce_rx_if #(.N(16)) bus ();

    sw_debounce_rx #(
        .N              (16),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) u_dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    // Reference: level accepted once the synchronized value (input two
    // edges old) differed from the clean level on each of the last D edges
    // since the previous acceptance or reset.
    logic [15:0] hist[$] = '{16'h0, 16'h0};
    int          t = 0;
    int          last_acc[16];
    logic [15:0] m_clean = '0;
    logic [15:0] m_rise  = '0;
    logic [15:0] m_fall  = '0;
    logic [7:0]  m_cnt   = '0;

    initial for (int i = 0; i < 16; i++) last_acc[i] = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist    = '{16'h0, 16'h0};
            t       = 0;
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_cnt   = '0;
            for (int i = 0; i < 16; i++) last_acc[i] = 0;
        end else begin
            logic [15:0] nr;
            logic [15:0] nf;
            bit          ok;
            t++;
            if ((m_rise | m_fall) != 16'h0) m_cnt = m_cnt + 8'd1;
            nr = '0;
            nf = '0;
            for (int c = 0; c < 16; c++) begin
                if (t - last_acc[c] >= D) begin
                    ok = 1'b1;
                    for (int u = t - D + 1; u <= t; u++)
                        if (hist[u-1][c] == m_clean[c]) ok = 1'b0;
                    if (ok) begin
                        nr[c]       = ~m_clean[c];
                        nf[c]       = m_clean[c];
                        m_clean[c]  = ~m_clean[c];
                        last_acc[c] = t;
                    end
                end
            end
            m_rise = nr;
            m_fall = nf;
            hist.push_back(bus.SW);
        end
    end

    always @(negedge clk) begin
        logic m_evt;
        m_evt = |(m_rise | m_fall);
        checks++;
        if (bus.SW_CLEAN !== m_clean || bus.SW_RISE !== m_rise ||
            bus.SW_FALL !== m_fall || bus.SW_EVENT !== m_evt ||
            bus.EVT_CNT !== m_cnt) begin
            failures++;
            $display("FAIL model t=%0d clean=%h/%h rise=%h/%h fall=%h/%h evt=%b/%b cnt=%0d/%0d (actual/required)",
                     t, bus.SW_CLEAN, m_clean, bus.SW_RISE, m_rise,
                     bus.SW_FALL, m_fall, bus.SW_EVENT, m_evt,
                     bus.EVT_CNT, m_cnt);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Watch one channel for n cycles; lat = first cycle its clean level
    // differs from the starting level (0 if it never does).
    task automatic watch(input int ch, input int n, output int rises,
                         output int falls, output int lat);
        logic start;
        start = bus.SW_CLEAN[ch];
        rises = 0;
        falls = 0;
        lat   = 0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (bus.SW_RISE[ch]) rises++;
            if (bus.SW_FALL[ch]) falls++;
            if (lat == 0 && bus.SW_CLEAN[ch] !== start) lat = j;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r, f, lat, bad;
        rst    = 1'b0;
        bus.SW = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_clean", bus.SW_CLEAN, 0);
        chk("reset_cnt", bus.EVT_CNT, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 256 accepted toggles on SW[5]: counter wraps back to 0.
        bad = 0;
        for (int e = 1; e <= 256; e++) begin
            bus.SW[5] = ~bus.SW[5];
            watch(5, 7, r, f, lat);
            if (lat != 6 || r + f != 1) bad++;
            if (e == 255) chk("wrap_255", bus.EVT_CNT, 255);
        end
        chk("wrap_bad_events", bad, 0);
        chk("wrap_cnt", bus.EVT_CNT, 0);
        chk("wrap_clean5", bus.SW_CLEAN[5], 0);

        // Clean step on SW[0].
        bus.SW[0] = 1'b1;
        watch(0, 10, r, f, lat);
        chk("step_edges", lat - 1, 5);
        chk("step_rise_count", r, 1);
        chk("step_fall_count", f, 0);
        chk("step_cnt", bus.EVT_CNT, 1);

        // Bounce on SW[3]: 1,0,1,0 two cycles each, then hold 1.
        for (int p = 0; p < 4; p++) begin
            bus.SW[3] = (p % 2 == 0);
            repeat (2) @(negedge clk);
        end
        chk("bounce_mid_clean", bus.SW_CLEAN[3], 0);
        bus.SW[3] = 1'b1;
        watch(3, 12, r, f, lat);
        chk("bounce_edges", lat - 1, 5);
        chk("bounce_rise_count", r, 1);
        chk("bounce_cnt", bus.EVT_CNT, 2);

        // Three-cycle glitch on SW[7] is rejected.
        bus.SW[7] = 1'b1;
        repeat (3) @(negedge clk);
        bus.SW[7] = 1'b0;
        watch(7, 12, r, f, lat);
        chk("glitch_lat", lat, 0);
        chk("glitch_pulses", r + f, 0);
        chk("glitch_clean", bus.SW_CLEAN[7], 0);
        chk("glitch_cnt", bus.EVT_CNT, 2);

        // Bring SW[2] to clean 1, then rise on 1 and fall on 2 together.
        bus.SW[2] = 1'b1;
        watch(2, 10, r, f, lat);
        chk("ch2_edges", lat - 1, 5);
        bus.SW[1] = 1'b1;
        bus.SW[2] = 1'b0;
        lat = 0;
        for (int j = 1; j <= 20 && lat == 0; j++) begin
            @(negedge clk);
            if (bus.SW_EVENT) lat = j;
        end
        chk("sim_edges", lat - 1, 5);
        chk("sim_rise", bus.SW_RISE, 16'h0002);
        chk("sim_fall", bus.SW_FALL, 16'h0004);
        chk("sim_cnt_during", bus.EVT_CNT, 3);
        @(negedge clk);
        chk("sim_event_after", bus.SW_EVENT, 0);
        chk("sim_cnt_after", bus.EVT_CNT, 4);
        chk("sim_clean", bus.SW_CLEAN, 16'h000B);

        // Reset in the middle of debouncing SW=FFFF.
        bus.SW = 16'hFFFF;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_clean", bus.SW_CLEAN, 0);
        chk("rst_cnt", bus.EVT_CNT, 0);
        chk("rst_pulses", bus.SW_RISE | bus.SW_FALL, 0);
        chk("rst_event", bus.SW_EVENT, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int j = 1; j <= 20 && lat == 0; j++) begin
            @(negedge clk);
            if (bus.SW_CLEAN != 16'h0) lat = j;
        end
        chk("rst_rel_edges", lat - 1, 5);
        chk("rst_rel_clean", bus.SW_CLEAN, 16'hFFFF);
        chk("rst_rel_rise", bus.SW_RISE, 16'hFFFF);
        @(negedge clk);
        chk("rst_rel_rise_off", bus.SW_RISE, 0);
        chk("rst_rel_cnt", bus.EVT_CNT, 1);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
